// File: rtl/dpbram_bytewr_clr.sv
// True dual-port RAM with byte write enables, read-first collisions, read-valid
// tracking, out-of-range protection and a two-port zero-fill engine. Optional: DPBRAM_OUTREG_EN.
module dpbram_bytewr_clr #(
  parameter  int DWIDTH   = 32,
  parameter  int AWIDTH   = 10,
  parameter  int MEM_SIZE = 650,
  localparam int NB       = DWIDTH/8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic              ce0,
  input  logic              ce1,
  input  logic [NB-1:0]     we0,
  input  logic [NB-1:0]     we1,
  input  logic [DWIDTH-1:0] d0,
  input  logic [DWIDTH-1:0] d1,
  output logic [DWIDTH-1:0] q0,
  output logic [DWIDTH-1:0] q1,
  output logic              qv0,
  output logic              qv1,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_done
);
  localparam int NP = 2;
  localparam logic [AWIDTH:0] MS  = MEM_SIZE[AWIDTH:0];
  localparam logic [AWIDTH:0] ONE = 1;
  localparam logic [AWIDTH:0] TWO = 2;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} st_t;
  st_t state, state_nx;
  logic [AWIDTH:0] ptr, ptr_nx, ptr1;
  logic            clr_w1;

  logic [DWIDTH-1:0] mem [MEM_SIZE];

  logic [NP-1:0][AWIDTH-1:0] addr;
  logic [NP-1:0][NB-1:0]     we;
  logic [NP-1:0][DWIDTH-1:0] d;
  logic [NP-1:0]             ce, inr, wr, rd;
  logic [NP-1:0][DWIDTH-1:0] q_s;
  logic [NP-1:0]             qv_s;

  assign addr = {addr1, addr0};
  assign we   = {we1, we0};
  assign d    = {d1, d0};
  assign ce   = {ce1, ce0};

  assign busy     = (state != IDLE);
  assign clr_done = (state == DONE);
  assign ptr1     = ptr + ONE;
  assign clr_w1   = (ptr1 < MS);

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign inr[p] = ({1'b0, addr[p]} < MS);
    assign wr[p]  = ce[p] & ~busy & (|we[p]) & inr[p];
    assign rd[p]  = ce[p] & ~busy & ~(|we[p]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      IDLE:  if (clr_start) begin
               state_nx = CLEAR;
               ptr_nx   = '0;
             end
      CLEAR: begin
               ptr_nx = ptr + TWO;
               if (ptr + TWO >= MS) state_nx = DONE;
             end
      DONE:  begin
               state_nx = IDLE;
               ptr_nx   = '0;
             end
      default: state_nx = IDLE;
    endcase
  end

  // Port 1 bytes are written first so a port 0 write to the same byte overrides it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr[AWIDTH-1:0]] <= '0;
      if (clr_w1) mem[ptr1[AWIDTH-1:0]] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (wr[1] && we[1][b]) mem[addr[1]][b*8 +: 8] <= d[1][b*8 +: 8];
        if (wr[0] && we[0][b]) mem[addr[0]][b*8 +: 8] <= d[0][b*8 +: 8];
      end
    end
  end

  // Reads see the pre-edge array contents, giving read-first collision behaviour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_s  <= '0;
      qv_s <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        qv_s[p] <= rd[p];
        if (rd[p]) q_s[p] <= inr[p] ? mem[addr[p]] : '0;
      end
    end
  end

`ifdef DPBRAM_OUTREG_EN
  logic [NP-1:0][DWIDTH-1:0] q_r;
  logic [NP-1:0]             qv_r;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_r  <= '0;
      qv_r <= '0;
    end else begin
      q_r  <= q_s;
      qv_r <= qv_s;
    end
  end
  assign q0  = q_r[0];
  assign q1  = q_r[1];
  assign qv0 = qv_r[0];
  assign qv1 = qv_r[1];
`else
  assign q0  = q_s[0];
  assign q1  = q_s[1];
  assign qv0 = qv_s[0];
  assign qv1 = qv_s[1];
`endif
endmodule

// File: doc/dpbram_bytewr_clr.md
# dpbram_bytewr_clr

Parametrised true dual-port synchronous RAM for accelerator feature-map and weight buffers. It adds several features over the basic single-word dual-port buffer:
- per-byte write enables;
- defined same-address collision rules;
- read-valid tracking;
- out-of-range address protection;
- a built-in clear engine that zero-fills the array using both ports.

It sits between the AXI/DMA loaders and the PE array. Both ports are independently usable whenever the clear engine is idle.

## Interface
Parameters:
- DWIDTH, 32: data width in bits; must be a multiple of 8.
- AWIDTH, 10: address width.
- MEM_SIZE, 650: number of words; must satisfy 2 ≤ MEM_SIZE ≤ 2^AWIDTH.
- NB, DWIDTH/8: byte lanes (derived, not overridden).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- addr0 / addr1  in  AWIDTH  port 0 / port 1 word address.
- ce0 / ce1  in  1  port access enable.
- we0 / we1  in  NB  byte write enables; any bit set = write access, all zero = read access.
- d0 / d1  in  DWIDTH  write data.
- q0 / q1  out  DWIDTH  read data.
- qv0 / qv1  out  1  read data valid, aligned with q0 / q1.
- clr_start  in  1  single-cycle request to zero-fill the whole array.
- busy  out  1  clear engine active; external accesses are ignored.
- clr_done  out  1  one-cycle pulse when clearing completes.

## Operation
- Port access requires ce=1 and busy=0.
- Writes:
  - Bytes with a set we bit are written; the other bytes keep their old value.
  - A write holds q and deasserts qv (no write-through).
- Reads:
  - A read access (we=0) returns ram[addr] on q.
  - qv pulses high with the data.
  - q holds its value until the next read on the same port.
- Out-of-range address (addr ≥ MEM_SIZE): the write is dropped; a read returns 0 with qv=1.
- Collisions:
  - Both ports write the same address in one cycle: port 0 wins on bytes enabled on both ports. Bytes enabled only on port 1 are still written.
  - One port reads an address the other port writes in the same cycle: the read returns the old data (read-first).
- Clear FSM has three states: IDLE, CLEAR, DONE.
  - IDLE: clr_start=1 → CLEAR, with ptr=0.
  - CLEAR: writes zero to ptr via port 0 and to ptr+1 via port 1; the port 1 write is skipped if ptr+1 ≥ MEM_SIZE. ptr += 2. Go to DONE when ptr+2 ≥ MEM_SIZE, otherwise stay in CLEAR.
  - DONE: clr_done=1 for one cycle, then → IDLE.
  - busy = (state ≠ IDLE).
  - clr_start is ignored while busy.
  - External ce/we are ignored while busy, and qv stays 0.
- Reset effects:
  - Reset puts the FSM in IDLE and sets ptr=0.
  - Array contents are not reset.
  - Reset during CLEAR aborts the clear; the array is left partially cleared and clr_done is not pulsed.

## Timing
- Reset values: q0=q1=0, qv0=qv1=0, busy=0, clr_done=0.
- Read latency is 1 cycle without the output register: address presented at edge N → q/qv valid after edge N+1.
- Write takes effect at the sampling edge; a read at the next edge returns the new data.
- clr_start sampled at edge N → busy=1 from edge N+1.
- Clear duration:
  - CLEAR lasts ceil(MEM_SIZE/2) cycles, then one DONE cycle.
  - With MEM_SIZE=650: 325 CLEAR cycles plus 1 DONE cycle, so busy is high for 326 cycles.
  - clr_done goes high in the cycle where busy falls, i.e. in the last busy cycle.
- The first external access after a clear is accepted at the edge where busy is already 0.

## Configuration
- Macro: DPBRAM_OUTREG_EN.
- Defined:
  - An extra output register stage is added per port.
  - Read latency becomes 2 cycles, and qv is pipelined identically.
  - The output registers reset to 0.
  - Collision and out-of-range rules are unchanged.
- Undefined: 1-cycle read latency as specified above.

## Test plan
- Byte write: write 0xAABBCCDD to addr 5 with we0=4'hF, then 0x11223344 with we0=4'b0101, then read → q0=0xAA22CC44 and qv0=1 at the stated latency.
- Write collision: same cycle, port 0 writes 0x1 and port 1 writes 0x2 to addr 7, both we=4'hF → later read returns 0x00000001.
- Read-first collision: addr 9 holds 0x5; port 1 reads addr 9 while port 0 writes 0x6 to it → q1=0x5; the next read returns 0x6.
- Out-of-range: write 0xFFFFFFFF to addr 700 (MEM_SIZE=650) → no array change; read addr 700 → q=0, qv=1.
- Clear:
  - Fill all addresses with 0xDEADBEEF, pulse clr_start → busy high for exactly 326 cycles, clr_done pulses once, all 650 words read back 0.
  - ce accesses issued while busy have no effect.
- Reset mid-clear: assert reset_n=0 at CLEAR cycle 100 → busy=0, q=0, qv=0 immediately, no clr_done. Addresses 0..199 read 0; addresses 200..649 keep 0xDEADBEEF.
